rr_decoder_arbiter: RTL and testbench



---
 rtl/rr_decoder_arbiter_if.sv | 25 ++
 rtl/rr_decoder_arbiter.sv | 92 +++++++++
 tb/tb_rr_decoder_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between eight requesters and the arbiter.
// The arbiter sits on the slave side; requesters drive req_in.
interface rr_decoder_arbiter_if;
  logic [7:0] req_in;
  logic [7:0] gnt_out;
  logic [2:0] gnt_idx_out;
  logic       gnt_valid_out;
  logic       timeout_out;

  modport master (
    output req_in,
    input  gnt_out,
    input  gnt_idx_out,
    input  gnt_valid_out,
    input  timeout_out
  );

  modport slave (
    input  req_in,
    output gnt_out,
    output gnt_idx_out,
    output gnt_valid_out,
    output timeout_out
  );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Eight-way round-robin arbiter with a hold limit.
// Grant index is registered and decoded to a one-hot grant.
module rr_decoder_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input logic                clk_in,
  input logic                rst_in,
  rr_decoder_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HOLD);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       ptr;
  logic [7:0]       gnt_r;
  logic [2:0]       idx_r;
  logic             valid_r;
  logic             to_r;

  logic [2:0]       win;
  logic [2:0]       cand;
  logic             found;

  function automatic logic [7:0] dec3to8(input logic [2:0] i);
    return 8'(1) << i;
  endfunction

  // Scan from the slot after the last grant so it becomes lowest priority.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ptr + 3'(i);
      if (!found && bus.req_in[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Grant FSM; every release passes through IDLE, giving one dead cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= 3'd7;
      gnt_r   <= '0;
      idx_r   <= '0;
      valid_r <= 1'b0;
      to_r    <= 1'b0;
    end else begin
      to_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|bus.req_in) begin
            state   <= GRANT;
            idx_r   <= win;
            gnt_r   <= dec3to8(win);
            valid_r <= 1'b1;
            cnt     <= CNT_W'(1);
          end
        end
        GRANT: begin
          if (!bus.req_in[idx_r] || cnt == MAX_C) begin
            state   <= IDLE;
            ptr     <= idx_r;
            idx_r   <= '0;
            gnt_r   <= '0;
            valid_r <= 1'b0;
            cnt     <= '0;
            to_r    <= bus.req_in[idx_r];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_out       = gnt_r;
  assign bus.gnt_idx_out   = idx_r;
  assign bus.gnt_valid_out = valid_r;
  assign bus.timeout_out   = to_r;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed scoreboard bench for rr_decoder_arbiter.
// Expected outputs are queued per step and popped after each edge.
module tb_rr_decoder_arbiter;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       v;
    logic       t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  rr_decoder_arbiter_if bus ();

  rr_decoder_arbiter dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t grant(input int k);
    exp_t e;
    e.gnt = 8'(1) << k;
    e.idx = 3'(k);
    e.v   = 1'b1;
    e.t   = 1'b0;
    return e;
  endfunction

  function automatic exp_t idle(input logic t);
    exp_t e;
    e = '0;
    e.t = t;
    return e;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_gnt"},   32'(bus.gnt_out),       32'(e.gnt));
    chk({tag, "_idx"},   32'(bus.gnt_idx_out),   32'(e.idx));
    chk({tag, "_valid"}, 32'(bus.gnt_valid_out), 32'(e.v));
    chk({tag, "_tout"},  32'(bus.timeout_out),   32'(e.t));
  endtask

  task automatic now_zero(input string tag);
    sb.push_back(idle(1'b0));
    compare(tag);
  endtask

  task automatic step(input logic [7:0] r, input exp_t e,
                      input string tag);
    bus.req_in = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    now_zero(tag);
    rst = 1'b0;
  endtask

  // Structural invariants sampled mid-cycle.
  always @(negedge clk) begin
    chk("inv_onehot", 32'($onehot0(bus.gnt_out)), 1);
    chk("inv_dec", 32'(bus.gnt_out),
        bus.gnt_valid_out ? (32'd1 << bus.gnt_idx_out) : 32'd0);
    chk("inv_valid", 32'(bus.gnt_valid_out), 32'(|bus.gnt_out));
    if (bus.timeout_out)
      chk("inv_tout_valid", 32'(bus.gnt_valid_out), 0);
  end

  initial begin
    bus.req_in = 8'hFF;
    #3;
    now_zero("rst_mid");
    @(posedge clk);
    #1;
    now_zero("rst_edge");
    rst = 1'b0;
    for (int i = 0; i < 5; i++)
      step(8'h00, idle(1'b0), "idle");

    step(8'h04, grant(2), "single_grant");
    for (int i = 0; i < 3; i++)
      step(8'h04, grant(2), "single_hold");
    step(8'h00, idle(1'b0), "single_rel");
    step(8'h00, idle(1'b0), "single_idle");

    pulse_reset("rst_rr");
    for (int k = 0; k <= 8; k++) begin
      step(8'hFF, grant(k % 8), "rr_grant");
      step(8'hFF & ~(8'(1) << (k % 8)), idle(1'b0), "rr_dead");
    end
    step(8'h00, idle(1'b0), "rr_end");

    step(8'h01, grant(0), "hold_first");
    for (int i = 1; i < 15; i++)
      step(8'h01, grant(0), "hold_cycle");
    step(8'h01, idle(1'b1), "hold_timeout");
    step(8'h01, grant(0), "hold_regrant");
    step(8'h00, idle(1'b0), "hold_rel");
    step(8'h00, idle(1'b0), "hold_idle");

    pulse_reset("rst_fair");
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 15; i++)
        step(8'h03, grant(r % 2), "fair_grant");
      step(8'h03, idle(1'b1), "fair_timeout");
    end
    step(8'h00, idle(1'b0), "fair_end");

    step(8'h20, grant(5), "async_grant");
    step(8'h20, grant(5), "async_hold");
    #4;
    rst = 1'b1;
    #1;
    now_zero("async_clear");
    bus.req_in = 8'hFF;
    @(posedge clk);
    #1;
    now_zero("async_held");
    rst = 1'b0;
    step(8'hFF, grant(0), "async_first");
    step(8'h00, idle(1'b0), "async_rel");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
